// File: rtl/memory_arbiter.sv
// Shares one RAM port between the instruction and data requesters; data has priority.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_EN.
module memory_arbiter #(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_t state_r;
  state_t state_next_s;
  logic   d_req_s;
  logic   i_access_s;
  logic   d_access_s;
  logic   force_i_s;

  // A completion only counts while the granted requester still holds its request
  assign d_req_s    = dREN | dWEN;
  assign i_access_s = (state_r == IGRANT) && (ramstate == RAM_ACCESS) && iREN;
  assign d_access_s = (state_r == DGRANT) && (ramstate == RAM_ACCESS) && d_req_s;

`ifdef MEM_ARB_STARVE_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_r;

  // Count data completions that left a pending instruction request waiting
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt_r <= 4'd0;
    end else if (i_access_s) begin
      starve_cnt_r <= 4'd0;
    end else if (d_access_s && iREN && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign force_i_s = (starve_cnt_r == STARVE_MAX) && iREN;
`else
  logic unused_limit_s;
  assign unused_limit_s = ^(4'(STARVE_LIMIT));
  assign force_i_s      = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Arbitration, abort, completion and error-retry transitions
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (force_i_s) begin
          state_next_s = IGRANT;
        end else if (d_req_s) begin
          state_next_s = DGRANT;
        end else if (iREN) begin
          state_next_s = IGRANT;
        end else begin
          state_next_s = IDLE;
        end
      end
      IGRANT: begin
        if (!iREN || (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = IGRANT;
        end
      end
      DGRANT: begin
        if (!d_req_s || (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DGRANT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // RAM port steering from the current winner
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_r)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  assign iwait = ~i_access_s;
  assign dwait = ~d_access_s;
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter that shares the single RAM port between the instruction-fetch requester (icache side) and the data requester (dcache side) of the pipelined MIPS core. It grants one requester at a time, drives the RAM enables, address and store data from the winner, and holds the loser in wait until the RAM reports ACCESS. Data requests have priority. An optional starvation guard forces an instruction grant after a bounded run of data grants.

## Interface
- WORD_W, 32, width of address, store and load words
- STARVE_LIMIT, 4, consecutive data grants with a pending instruction request before instruction is forced; legal range 1..15
- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  WORD_W  instruction address
- iwait  out  1  high while instruction request not yet serviced
- iload  out  WORD_W  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  data write value
- dwait  out  1  high while data request not yet serviced
- dload  out  WORD_W  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

## Operation
- Clock is CLK; reset nRST is asynchronous and active-low.
- States: IDLE, IGRANT, DGRANT.
- IDLE: ram enables 0. Next state: DGRANT if dREN|dWEN (unless starvation forces), else IGRANT if iREN, else IDLE.
- DGRANT: ramaddr=daddr; ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both set); ramstore=dstore.
- IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion: in a grant state with ramstate==ACCESS, the granted wait drops to 0 combinationally that cycle; next state IDLE.
- ERROR: wait stays 1; next state IDLE; request re-arbitrated (retry).
- Abort: granted requester deasserts all its enables before ACCESS → next state IDLE, no completion signalled.
- iload=dload=ramload (pass-through, unqualified).
- iwait = ~(state==IGRANT & ramstate==ACCESS); dwait = ~(state==DGRANT & ramstate==ACCESS).
- Starvation counter (4 bits): increments on each data completion while iREN is high, saturates at STARVE_LIMIT; clears on instruction completion. In IDLE with counter==STARVE_LIMIT and iREN high → IGRANT regardless of data request.
- Reset values: state IDLE, counter 0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1. Reset mid-grant aborts immediately; RAM enables drop asynchronously.

## Timing
- Grant latency: request seen in IDLE at cycle 0 → RAM enables asserted cycle 1.
- Minimum transaction: 3 cycles (IDLE, grant with ACCESS, back to IDLE); back-to-back requests from the same requester therefore have one idle cycle between them.
- Address/store data must be held stable by the requester while its wait is high; arbiter does not register them.
- Simultaneous iREN and dREN in IDLE: data wins unless starvation forces instruction.
- ACCESS and requester drop in same cycle: treated as abort; wait stays high.

## Configuration
- MEM_ARB_STARVE_EN: defined → starvation counter and forced IGRANT present as above. Undefined → counter absent, strict data priority, STARVE_LIMIT ignored.

## Test plan
- Reset: nRST=0 mid-DGRANT → ramREN=ramWEN=0, iwait=dwait=1 immediately, state IDLE after release.
- Single instruction read: iREN=1, iaddr=0x100, ramstate ACCESS on cycle 2 with ramload=0xDEADBEEF → ramREN=1 cycles 1–2, iwait=0 only on cycle 2, iload=0xDEADBEEF.
- Contention: iREN and dWEN both 1, daddr=0x200, dstore=0x1234 → DGRANT first with ramWEN=1, ramstore=0x1234; IGRANT follows after one IDLE cycle.
- Error retry: DGRANT read, ramstate ERROR then ACCESS on re-grant → dwait stays 1 through ERROR, drops only on second grant's ACCESS.
- Starvation (macro on, STARVE_LIMIT=2): iREN held, dREN continuous → after 2 data completions next grant is IGRANT; macro off → IGRANT never occurs while dREN held.
- Abort: DGRANT, dREN dropped before ACCESS → ram enables 0 next cycle, dwait stays 1, counter unchanged.
